// File: rtl/chess_pkg.sv
// chess_pkg
// Shared types and constants for the chess move-generation blocks.
// No ports; imported by the sequencer and its helpers.
package chess_pkg;

    // Signed piece code stored in each board byte; white positive, black negative.
    typedef logic signed [7:0] square_t;

    localparam square_t PIECE_EMPTY = 8'sd0;
    localparam square_t PIECE_PAWN  = 8'sd1;

    // Register map of the pawn move-generator slave port.
    localparam logic [3:0] GEN_REG_START = 4'd0;
    localparam logic [3:0] GEN_REG_SRC   = 4'd1;
    localparam logic [3:0] GEN_REG_DST   = 4'd2;
    localparam logic [3:0] GEN_REG_X     = 4'd3;
    localparam logic [3:0] GEN_REG_Y     = 4'd4;

    // True when the square holds a pawn of the side to move (0 = white, 1 = black).
    function automatic logic is_own_pawn(input square_t value, input logic side);
        return side ? (value == square_t'(-PIECE_PAWN)) : (value == PIECE_PAWN);
    endfunction

endpackage

// File: rtl/pawn_sched_if.sv
// pawn_sched_if
// Avalon-MM style bus bundle used for the CPU slave port, the SDRAM master
// port and the generator master port of pawn_sched.
//   waitrequest   : stall from the slave side
//   address       : register select / byte address (AW bits)
//   read, write   : strobes from the master side
//   readdata      : read data from the slave side
//   writedata     : write data from the master side
//   readdatavalid : pipelined read return from the slave side
interface pawn_sched_if #(parameter int AW = 32);
    logic          waitrequest;
    logic [AW-1:0] address;
    logic          read;
    logic [31:0]   readdata;
    logic          write;
    logic [31:0]   writedata;
    logic          readdatavalid;

    modport master (
        input  waitrequest, readdata, readdatavalid,
        output address, read, write, writedata
    );

    modport slave (
        output waitrequest, readdata, readdatavalid,
        input  address, read, write, writedata
    );
endinterface

// File: rtl/pawn_sched_av_hold_req.sv
// av_hold_req
// Presents one Avalon request (read or write) on a master port and reports
// when the slave has taken it. The request fields are supplied by the owning
// FSM, which only moves on when o_accept is high, so strobe, address and data
// stay stable for the whole stall.
//   i_req, i_is_read         : request present / request is a read
//   i_address, i_writedata   : request fields
//   i_waitrequest            : slave stall
//   o_read, o_write          : strobes to the slave
//   o_address, o_writedata   : fields to the slave (zero when idle)
//   o_accept                 : request completes this cycle
module av_hold_req
    import chess_pkg::*;
(
    input  logic        i_req,
    input  logic        i_is_read,
    input  logic [3:0]  i_address,
    input  logic [31:0] i_writedata,
    input  logic        i_waitrequest,
    output logic        o_read,
    output logic        o_write,
    output logic [3:0]  o_address,
    output logic [31:0] o_writedata,
    output logic        o_accept
);
    assign o_read      = i_req & i_is_read;
    assign o_write     = i_req & ~i_is_read;
    assign o_address   = i_req ? i_address : GEN_REG_START;
    assign o_writedata = o_write ? i_writedata : 32'd0;
    assign o_accept    = i_req & ~i_waitrequest;
endmodule

// File: rtl/pawn_sched.sv
// pawn_sched
// Scans a 64-square board in SDRAM for pawns of the side to move and, for
// each one, programs and runs the pawn move generator, giving every run its
// own SLOT_BYTES output slot starting at the destination base.
//   clk, rst_n : clock, synchronous active-low reset
//   slave      : CPU register port (0 start/blocking count, 1 src, 2 dst,
//                3 side, 4 count)
//   master     : SDRAM read port, square byte in readdata[7:0]
//   gen        : generator register port
module pawn_sched
    import chess_pkg::*;
#(
    parameter int SLOT_BYTES = 256,
    parameter int MAX_SQ     = 64
)(
    input  logic         clk,
    input  logic         rst_n,
    pawn_sched_if.slave  slave,
    pawn_sched_if.master master,
    pawn_sched_if.master gen
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LATCH   = 4'd1;
    localparam logic [3:0] S_ACK     = 4'd2;
    localparam logic [3:0] S_RD_SQ   = 4'd3;
    localparam logic [3:0] S_WAIT_SQ = 4'd4;
    localparam logic [3:0] S_CHECK   = 4'd5;
    localparam logic [3:0] S_G_SRC   = 4'd6;
    localparam logic [3:0] S_G_DST   = 4'd7;
    localparam logic [3:0] S_G_X     = 4'd8;
    localparam logic [3:0] S_G_Y     = 4'd9;
    localparam logic [3:0] S_G_GO    = 4'd10;
    localparam logic [3:0] S_G_WAIT  = 4'd11;
    localparam logic [3:0] S_NEXT    = 4'd12;
    localparam logic [3:0] S_DONE    = 4'd13;

    localparam logic [5:0] LAST_SQ = 6'(MAX_SQ - 1);

    logic [3:0]  r_state;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [31:0] r_slot_addr;
    logic        r_side;
    logic [5:0]  r_sq;
    logic [7:0]  r_count;
    square_t     r_sq_val;
    logic [3:0]  r_wr_addr;
    logic [31:0] r_wr_data;

    logic        w_gen_req;
    logic        w_gen_is_read;
    logic [3:0]  w_gen_addr;
    logic [31:0] w_gen_data;
    logic        w_gen_accept;
    logic [31:0] w_reg_rdata;

    // Generator request selected by the current dispatch state.
    always_comb begin
        w_gen_req     = 1'b0;
        w_gen_is_read = 1'b0;
        w_gen_addr    = GEN_REG_START;
        w_gen_data    = 32'd0;
        case (r_state)
            S_G_SRC:  begin w_gen_req = 1'b1; w_gen_addr = GEN_REG_SRC; w_gen_data = r_src; end
            S_G_DST:  begin w_gen_req = 1'b1; w_gen_addr = GEN_REG_DST; w_gen_data = r_slot_addr; end
            S_G_X:    begin w_gen_req = 1'b1; w_gen_addr = GEN_REG_X;   w_gen_data = {29'd0, r_sq[2:0]}; end
            S_G_Y:    begin w_gen_req = 1'b1; w_gen_addr = GEN_REG_Y;   w_gen_data = {29'd0, r_sq[5:3]}; end
            S_G_GO:   begin w_gen_req = 1'b1; w_gen_addr = GEN_REG_START; end
            // The generator's start register stalls reads until it has finished.
            S_G_WAIT: begin w_gen_req = 1'b1; w_gen_is_read = 1'b1; w_gen_addr = GEN_REG_START; end
            default:  ;
        endcase
    end

    av_hold_req u_gen_req (
        .i_req         (w_gen_req),
        .i_is_read     (w_gen_is_read),
        .i_address     (w_gen_addr),
        .i_writedata   (w_gen_data),
        .i_waitrequest (gen.waitrequest),
        .o_read        (gen.read),
        .o_write       (gen.write),
        .o_address     (gen.address),
        .o_writedata   (gen.writedata),
        .o_accept      (w_gen_accept)
    );

    assign master.read      = (r_state == S_RD_SQ);
    assign master.address   = master.read ? (r_src + {26'd0, r_sq}) : 32'd0;
    assign master.write     = 1'b0;
    assign master.writedata = 32'd0;

    // Register readback used by non-blocking reads while idle.
    always_comb begin
        case (slave.address)
            4'd1:       w_reg_rdata = r_src;
            4'd2:       w_reg_rdata = r_dst;
            4'd3:       w_reg_rdata = {31'd0, r_side};
            4'd0, 4'd4: w_reg_rdata = {24'd0, r_count};
            default:    w_reg_rdata = 32'd0;
        endcase
    end

    // The CPU is only served while idle, or in DONE for the completion read;
    // anything else stalls until the run ends.
    always_comb begin
        slave.waitrequest = 1'b1;
        slave.readdata    = 32'd0;
        case (r_state)
            S_IDLE: begin
                slave.waitrequest = 1'b0;
                if (slave.read) slave.readdata = w_reg_rdata;
            end
            S_DONE: begin
                if (slave.read && slave.address == 4'd0) begin
                    slave.waitrequest = 1'b0;
                    slave.readdata    = {24'd0, r_count};
                end
            end
            default: ;
        endcase
    end

    assign slave.readdatavalid = 1'b0;

    // Main sequencer: config writes, square scan, and one generator dispatch per pawn.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_src       <= 32'hFFFF_FFFF;
            r_dst       <= 32'hFFFF_FFFF;
            r_slot_addr <= 32'hFFFF_FFFF;
            r_side      <= 1'b0;
            r_sq        <= 6'd0;
            r_count     <= 8'd0;
            r_sq_val    <= PIECE_EMPTY;
            r_wr_addr   <= 4'd0;
            r_wr_data   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (slave.write) begin
                        if (slave.address == 4'd0) begin
                            r_state <= S_ACK;
                        end else if (slave.address <= 4'd3) begin
                            r_wr_addr <= slave.address;
                            r_wr_data <= slave.writedata;
                            r_state   <= S_LATCH;
                        end
                    end
                end
                S_LATCH: begin
                    case (r_wr_addr)
                        4'd1:    r_src  <= r_wr_data;
                        4'd2:    r_dst  <= r_wr_data;
                        4'd3:    r_side <= r_wr_data[0];
                        default: ;
                    endcase
                    r_state <= S_IDLE;
                end
                S_ACK: begin
                    r_sq        <= 6'd0;
                    r_count     <= 8'd0;
                    r_slot_addr <= r_dst;
                    r_state     <= S_RD_SQ;
                end
                S_RD_SQ:   if (!master.waitrequest) r_state <= S_WAIT_SQ;
                S_WAIT_SQ: begin
                    if (master.readdatavalid) begin
                        r_sq_val <= square_t'(master.readdata[7:0]);
                        r_state  <= S_CHECK;
                    end
                end
                S_CHECK:   r_state <= is_own_pawn(r_sq_val, r_side) ? S_G_SRC : S_NEXT;
                S_G_SRC:   if (w_gen_accept) r_state <= S_G_DST;
                S_G_DST:   if (w_gen_accept) r_state <= S_G_X;
                S_G_X:     if (w_gen_accept) r_state <= S_G_Y;
                S_G_Y:     if (w_gen_accept) r_state <= S_G_GO;
                S_G_GO:    if (w_gen_accept) r_state <= S_G_WAIT;
                S_G_WAIT: begin
                    if (w_gen_accept) begin
                        r_count     <= r_count + 8'd1;
                        r_slot_addr <= r_slot_addr + 32'(SLOT_BYTES);
                        r_state     <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (r_sq == LAST_SQ) begin
                        r_state <= S_DONE;
                    end else begin
                        r_sq    <= r_sq + 6'd1;
                        r_state <= S_RD_SQ;
                    end
                end
                S_DONE:    if (slave.read && slave.address == 4'd0) r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pawn_sched.sv
// tb_pawn_sched
// Self-checking bench for pawn_sched: SDRAM and generator responders with
// configurable stalls/latency, a board-level model of the expected generator
// traffic, and a per-cycle monitor comparing the DUT against that model.
module tb_pawn_sched;
    import chess_pkg::*;

    localparam int BUDGET = 20000;

    typedef struct packed {
        logic        isRead;
        logic [3:0]  addr;
        logic [31:0] data;
    } genTxn_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pawn_sched_if #(.AW(4))  cpuBus ();
    pawn_sched_if #(.AW(32)) memBus ();
    pawn_sched_if #(.AW(4))  genBus ();

    pawn_sched #(.SLOT_BYTES(256), .MAX_SQ(64)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .slave  (cpuBus),
        .master (memBus),
        .gen    (genBus)
    );

    int checks = 0;
    int errors = 0;

    logic signed [7:0] board [64];
    logic [31:0] cfgSrc = 32'd0;
    logic [31:0] cfgDst = 32'd0;
    logic        cfgSide = 1'b0;
    int          memStallCfg = 0;
    int          memLatCfg = 1;
    int          genStallCfg = 0;
    int          expCount;
    genTxn_t     expQ[$];
    int          memReads = 0;
    int          memBase = 0;
    logic [31:0] obsDst[$];
    logic [31:0] obsX = 32'd0;
    logic [31:0] obsY = 32'd0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: actual=timeout required=response within %0d cycles", name, BUDGET);
    endtask

    // Board-level model: every own pawn, in square order, gets five register
    // writes and one blocking read, with slots spaced 256 bytes apart.
    function automatic void buildModel();
        logic signed [7:0] own;
        logic [31:0]       slot;
        own  = cfgSide ? -8'sd1 : 8'sd1;
        slot = cfgDst;
        expQ.delete();
        expCount = 0;
        for (int sq = 0; sq < 64; sq++) begin
            if (board[sq] == own) begin
                expQ.push_back('{1'b0, 4'd1, cfgSrc});
                expQ.push_back('{1'b0, 4'd2, slot});
                expQ.push_back('{1'b0, 4'd3, 32'(sq % 8)});
                expQ.push_back('{1'b0, 4'd4, 32'(sq / 8)});
                expQ.push_back('{1'b0, 4'd0, 32'd0});
                expQ.push_back('{1'b1, 4'd0, 32'd0});
                slot = slot + 32'd256;
                expCount++;
            end
        end
    endfunction

    // SDRAM responder: optional stall per read, then data after memLatCfg cycles.
    initial begin
        int stallCnt;
        int pend;
        logic [31:0] pendAddr;
        logic [31:0] idx;
        stallCnt = 0;
        pend = 0;
        pendAddr = 32'd0;
        memBus.waitrequest   = 1'b0;
        memBus.readdatavalid = 1'b0;
        memBus.readdata      = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            memBus.readdatavalid = 1'b0;
            memBus.readdata      = $urandom;
            if (!rst_n) begin
                pend = 0;
                stallCnt = 0;
                memBus.waitrequest = 1'b0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        idx = pendAddr - cfgSrc;
                        memBus.readdatavalid = 1'b1;
                        memBus.readdata = {24'($urandom), board[idx[5:0]]};
                    end
                end
                if (memBus.read) begin
                    if (stallCnt < memStallCfg) begin
                        memBus.waitrequest = 1'b1;
                        stallCnt++;
                    end else begin
                        memBus.waitrequest = 1'b0;
                        stallCnt = 0;
                        pendAddr = memBus.address;
                        pend = memLatCfg;
                    end
                end else begin
                    memBus.waitrequest = 1'b0;
                end
            end
        end
    end

    // Generator responder: stalls each access for genStallCfg cycles.
    initial begin
        int stallCnt;
        stallCnt = 0;
        genBus.waitrequest   = 1'b0;
        genBus.readdata      = 32'd0;
        genBus.readdatavalid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            genBus.readdata = $urandom;
            if (!rst_n) begin
                stallCnt = 0;
                genBus.waitrequest = 1'b0;
            end else if (genBus.write || genBus.read) begin
                if (stallCnt < genStallCfg) begin
                    genBus.waitrequest = 1'b1;
                    stallCnt++;
                end else begin
                    genBus.waitrequest = 1'b0;
                    stallCnt = 0;
                end
            end else begin
                genBus.waitrequest = 1'b0;
            end
        end
    end

    // Per-cycle monitor: accepted generator and SDRAM requests against the
    // model, plus stability of any request held under waitrequest.
    logic        genPrevHold = 1'b0;
    logic [37:0] genPrevReq = '0;
    logic        memPrevHold = 1'b0;
    logic [31:0] memPrevAddr = 32'd0;
    genTxn_t     monTxn;
    always @(negedge clk) begin
        if (!rst_n) begin
            genPrevHold = 1'b0;
            memPrevHold = 1'b0;
        end else begin
            if (genPrevHold)
                checkOutput("gen_hold_stable", {genBus.read, genBus.write, genBus.address, genBus.writedata}, genPrevReq);
            if ((genBus.write || genBus.read) && !genBus.waitrequest) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL gen_unexpected: actual=rd%0d addr%0h data%0h required=no transaction",
                             genBus.read, genBus.address, genBus.writedata);
                end else begin
                    monTxn = expQ.pop_front();
                    checkOutput("gen_txn", {genBus.read, genBus.write, genBus.address, genBus.writedata},
                                {monTxn.isRead, ~monTxn.isRead, monTxn.addr, monTxn.data});
                end
                if (genBus.write && genBus.address == 4'd2) obsDst.push_back(genBus.writedata);
                if (genBus.write && genBus.address == 4'd3) obsX = genBus.writedata;
                if (genBus.write && genBus.address == 4'd4) obsY = genBus.writedata;
            end
            genPrevHold = (genBus.write || genBus.read) && genBus.waitrequest;
            genPrevReq  = {genBus.read, genBus.write, genBus.address, genBus.writedata};

            if (memPrevHold)
                checkOutput("mem_hold_stable", {memBus.read, memBus.address}, {1'b1, memPrevAddr});
            if (memBus.read && !memBus.waitrequest) begin
                checkOutput("mem_addr", memBus.address, cfgSrc + 32'(memReads - memBase));
                memReads++;
            end
            memPrevHold = memBus.read && memBus.waitrequest;
            memPrevAddr = memBus.address;
        end
    end

    task automatic cpuWrite(input logic [3:0] a, input logic [31:0] d);
        int n;
        @(posedge clk);
        #1;
        cpuBus.write = 1'b1;
        cpuBus.address = a;
        cpuBus.writedata = d;
        n = 0;
        @(negedge clk);
        while (cpuBus.waitrequest && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) timeoutFail("cpu_write");
        @(posedge clk);
        #1;
        cpuBus.write = 1'b0;
    endtask

    task automatic cpuRead(input logic [3:0] a, output logic [31:0] d);
        int n;
        @(posedge clk);
        #1;
        cpuBus.read = 1'b1;
        cpuBus.address = a;
        n = 0;
        @(negedge clk);
        while (cpuBus.waitrequest && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) timeoutFail("cpu_read");
        d = cpuBus.readdata;
        @(posedge clk);
        #1;
        cpuBus.read = 1'b0;
    endtask

    task automatic clearBoard();
        for (int i = 0; i < 64; i++) board[i] = 8'sd0;
    endtask

    task automatic startRun(input logic [31:0] src, input logic [31:0] dst, input logic side,
                            input int mStall, input int mLat, input int gStall);
        cfgSrc = src;
        cfgDst = dst;
        cfgSide = side;
        memStallCfg = mStall;
        memLatCfg = mLat;
        genStallCfg = gStall;
        buildModel();
        memBase = memReads;
        cpuWrite(4'd1, src);
        cpuWrite(4'd2, dst);
        cpuWrite(4'd3, {31'd0, side});
        cpuWrite(4'd0, 32'd0);
    endtask

    // One complete run: configure, start, block on completion, check totals.
    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input logic side,
                                 input int mStall, input int mLat, input int gStall,
                                 output logic [31:0] cnt);
        startRun(src, dst, side, mStall, mLat, gStall);
        cpuRead(4'd0, cnt);
        checkOutput("run_count", cnt, 64'(expCount));
        checkOutput("gen_txns_left", 64'(expQ.size()), 64'd0);
        checkOutput("squares_read", 64'(memReads - memBase), 64'd64);
    endtask

    initial begin
        logic [31:0] rd;
        int obsBase;
        int n;
        int v;
        cpuBus.read = 1'b0;
        cpuBus.write = 1'b0;
        cpuBus.address = 4'd0;
        cpuBus.writedata = 32'd0;
        rst_n = 1'b0;
        clearBoard();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_gen_strobes", {genBus.read, genBus.write}, 64'd0);
        checkOutput("rst_mem_read", memBus.read, 64'd0);
        checkOutput("rst_slave_wait", cpuBus.waitrequest, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cpuRead(4'd1, rd);  checkOutput("rst_src", rd, 64'hFFFF_FFFF);
        cpuRead(4'd2, rd);  checkOutput("rst_dst", rd, 64'hFFFF_FFFF);
        cpuRead(4'd4, rd);  checkOutput("rst_count", rd, 64'd0);

        $display("[TB] empty board");
        applyStimulus(32'h2000, 32'h1000, 1'b0, 0, 1, 0, rd);
        checkOutput("t1_count_lit", rd, 64'd0);
        cpuRead(4'd3, rd);  checkOutput("t1_side_reg", rd, 64'd0);

        $display("[TB] single white pawn at sq 12");
        clearBoard();
        board[12] = 8'sd1;
        obsBase = obsDst.size();
        applyStimulus(32'h2000, 32'h1000, 1'b0, 0, 1, 0, rd);
        checkOutput("t2_count_lit", rd, 64'd1);
        checkOutput("t2_x_lit", obsX, 64'd4);
        checkOutput("t2_y_lit", obsY, 64'd1);
        checkOutput("t2_ndst", 64'(obsDst.size() - obsBase), 64'd1);
        if (obsDst.size() > obsBase) checkOutput("t2_dst_lit", obsDst[obsBase], 64'h1000);

        $display("[TB] two white pawns, one black ignored");
        clearBoard();
        board[8] = 8'sd1;
        board[15] = 8'sd1;
        board[48] = -8'sd1;
        obsBase = obsDst.size();
        applyStimulus(32'h2000, 32'h1000, 1'b0, 0, 1, 0, rd);
        checkOutput("t3_count_lit", rd, 64'd2);
        checkOutput("t3_ndst", 64'(obsDst.size() - obsBase), 64'd2);
        if (obsDst.size() > obsBase + 1) begin
            checkOutput("t3_dst0_lit", obsDst[obsBase], 64'h1000);
            checkOutput("t3_dst1_lit", obsDst[obsBase + 1], 64'h1100);
        end

        $display("[TB] black pawn at sq 63");
        clearBoard();
        board[63] = -8'sd1;
        applyStimulus(32'h4000, 32'h8000, 1'b1, 0, 1, 0, rd);
        checkOutput("t4_count_lit", rd, 64'd1);
        checkOutput("t4_x_lit", obsX, 64'd7);
        checkOutput("t4_y_lit", obsY, 64'd7);
        cpuRead(4'd4, rd);  checkOutput("t4_count_reg", rd, 64'd1);

        $display("[TB] stalled buses");
        clearBoard();
        board[8] = 8'sd1;
        board[15] = 8'sd1;
        board[48] = -8'sd1;
        applyStimulus(32'h2000, 32'h1000, 1'b0, 2, 4, 5, rd);
        checkOutput("t5_count_lit", rd, 64'd2);

        $display("[TB] reset during generator wait");
        clearBoard();
        board[5] = 8'sd1;
        startRun(32'h3000, 32'h5000, 1'b0, 0, 1, 5);
        n = 0;
        @(negedge clk);
        while (!genBus.read && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_gwait_reached", genBus.read, 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t6_gwait_held", genBus.read, 64'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t6_rst_gen_read", genBus.read, 64'd0);
        checkOutput("t6_rst_gen_write", genBus.write, 64'd0);
        checkOutput("t6_rst_mem_read", memBus.read, 64'd0);
        checkOutput("t6_rst_slave_wait", cpuBus.waitrequest, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cpuRead(4'd1, rd);  checkOutput("t6_src_reset", rd, 64'hFFFF_FFFF);
        cpuRead(4'd4, rd);  checkOutput("t6_count_reset", rd, 64'd0);
        applyStimulus(32'h3000, 32'h5000, 1'b0, 0, 1, 0, rd);
        checkOutput("t6_count_lit", rd, 64'd1);

        $display("[TB] randomized boards");
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 64; i++) begin
                v = $urandom_range(0, 9);
                case (v)
                    0, 1, 2: board[i] = 8'sd1;
                    3, 4, 5: board[i] = -8'sd1;
                    6:       board[i] = 8'($urandom);
                    default: board[i] = 8'sd0;
                endcase
            end
            applyStimulus($urandom, (r == 2) ? 32'hFFFF_FE00 : 32'($urandom), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 5), rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
